// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl shared types.
// Segment type, scan states and hex glyph table.
package seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  // {a,b,c,d,e,f,g}, active-high, indexed by hex value
  localparam seg_t SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl content load handshake.
// Master offers digits and mask; slave accepts when ready.
interface seg_scan_ctrl_if #(
  parameter int NDIGITS = 4
);
  logic                   load_valid;
  logic                   load_ready;
  logic [4*NDIGITS-1:0]   load_data;
  logic [NDIGITS-1:0]     load_mask;

  modport master (
    output load_valid,
    output load_data,
    output load_mask,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_mask,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_ctrl_segmentdisplay.sv
// segmentdisplay: shared hex to seven-segment decoder.
// x1 is the nibble MSB.
module segmentdisplay
  import seg_pkg::*;
(
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output seg_t seg
);

  // table lookup of the glyph for the selected nibble
  always_comb begin
    seg = SEG_HEX[{x1, x2, x3, x4}];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Content swaps only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DIV     = 1000,
  parameter int BLANK   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  seg_scan_ctrl_if.slave     ld,
  output logic [NDIGITS-1:0] an,
  output seg_t               seg
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIGITS);

  state_e               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 pending;
  logic [4*NDIGITS-1:0] act_data;
  logic [4*NDIGITS-1:0] shd_data;
  logic [NDIGITS-1:0]   act_mask;
  logic [NDIGITS-1:0]   shd_mask;

  logic                 xfer;
  logic                 slot_last;
  logic                 frame_last;
  logic                 lit;
  logic [3:0]           nib;
  logic [NDIGITS-1:0]   oh;
  seg_t                 dec;

  assign ld.load_ready = ~pending;
  assign xfer       = ld.load_valid & ~pending;
  assign slot_last  = (cnt == CW'(DIV - 1));
  assign frame_last = slot_last & (idx == IW'(NDIGITS - 1));
  assign lit        = (cnt >= CW'(BLANK));

  // select the active nibble and one-hot anode for the current slot
  always_comb begin
    nib = '0;
    oh  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib   = act_data[4*i +: 4];
        oh[i] = 1'b1;
      end
    end
  end

  segmentdisplay u_dec (
    .x1  (nib[3]),
    .x2  (nib[2]),
    .x3  (nib[1]),
    .x4  (nib[0]),
    .seg (dec)
  );

  // scan FSM: slot/frame counters, content staging, registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      act_data <= '0;
      shd_data <= '0;
      act_mask <= '0;
      shd_mask <= '0;
      an       <= '0;
      seg      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          an  <= '0;
          seg <= '0;
          if (xfer) begin
            act_data <= ld.load_data;
            act_mask <= ld.load_mask;
            cnt      <= '0;
            idx      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          seg <= dec;
          an  <= (en && lit) ? (oh & ~act_mask) : '0;
          if (en) begin
            cnt <= slot_last ? '0 : cnt + CW'(1);
            if (slot_last)
              idx <= frame_last ? '0 : idx + IW'(1);
            if (frame_last && pending) begin
              act_data <= shd_data;
              act_mask <= shd_mask;
              pending  <= 1'b0;
            end
          end
          if (xfer) begin
            shd_data <= ld.load_data;
            shd_mask <= ld.load_mask;
            pending  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl.
// Frame-position reference model feeds an expected-output queue.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  seg_scan_ctrl_if #(.NDIGITS(ND)) ld ();

  seg_scan_ctrl #(
    .NDIGITS (ND),
    .DIV     (DIV),
    .BLANK   (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .ld  (ld),
    .an  (an),
    .seg (seg)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sbq [$];

  bit         m_scan;
  int         m_pos;
  bit         m_pend;
  logic [15:0] m_act, m_shd;
  logic [3:0]  m_am, m_sm;
  logic [3:0]  last_an;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_pos = 0; m_pend = 0;
    m_act = '0; m_shd = '0; m_am = '0; m_sm = '0;
  endtask

  // drive one cycle of inputs and queue the outputs expected after that edge
  task automatic step(input bit e, input bit v, input logic [15:0] d,
                      input logic [3:0] m, input bit r);
    exp_t x;
    int dig, off;
    bit xfer;
    logic [3:0] n;
    @(negedge clk);
    en = e; rst = r;
    ld.load_valid = v; ld.load_data = d; ld.load_mask = m;
    x.an = '0; x.seg = '0; x.rdy = 1'b1;
    if (r) begin
      model_reset();
    end else begin
      xfer = v && !m_pend;
      if (!m_scan) begin
        if (xfer) begin
          m_act = d; m_am = m; m_pos = 0; m_scan = 1;
        end
      end else begin
        dig   = m_pos / DIV;
        off   = m_pos % DIV;
        n     = 4'(m_act >> (4 * dig));
        x.seg = tbl[n];
        if (e && off >= BLANK && !m_am[dig]) x.an = 4'(1 << dig);
        if (e && m_pos == FRAME - 1 && m_pend) begin
          m_act = m_shd; m_am = m_sm; m_pend = 0;
        end
        if (e) m_pos = (m_pos + 1) % FRAME;
        if (xfer) begin
          m_shd = d; m_sm = m; m_pend = 1;
        end
      end
      x.rdy = !m_pend;
    end
    sbq.push_back(x);
    last_an = x.an;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 16'h0, 4'h0, 0);
  endtask

  // monitor: compare DUT outputs to queued expectations after each edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("an", 16'(an), 16'(x.an));
        chk("seg", 16'(seg), 16'(x.seg));
        chk("load_ready", 16'(ld.load_ready), 16'(x.rdy));
      end
    end
  end

  initial begin
    bit found;
    int guard;
    ld.load_valid = 0; ld.load_data = '0; ld.load_mask = '0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 4'h0, 1);
    run(20);

    step(1, 1, 16'h12AF, 4'h0, 0);
    run(40);

    while (m_pos != 12) step(1, 0, 16'h0, 4'h0, 0);
    step(1, 1, 16'h0008, 4'h0, 0);
    run(50);

    step(1, 1, 16'h0012, 4'b1100, 0);
    run(70);

    guard = 0;
    while (m_pos % DIV != 4 && guard < 100) begin
      step(1, 0, 16'h0, 4'h0, 0);
      guard++;
    end
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 4'h0, 0);
    run(20);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           16'($urandom), 4'($urandom), 0);

    guard = 0;
    while (m_pend && guard < 200) begin
      step(1, 0, 16'h0, 4'h0, 0);
      guard++;
    end
    step(1, 1, 16'h3456, 4'h0, 0);
    run(2 * FRAME);

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1, 0, 16'h0, 4'h0, 0);
      if (last_an == 4'b0100) found = 1;
    end
    chk("wait_an_0100", 16'(found), 16'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_an", 16'(an), 16'h0);
    chk("rst_seg", 16'(seg), 16'h0);
    chk("rst_ready", 16'(ld.load_ready), 16'h1);
    model_reset();
    step(1, 0, 16'h0, 4'h0, 1);
    run(15);
    step(1, 1, 16'hC0DE, 4'b0010, 0);
    run(40);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
